fifo_flags: RTL and testbench
=============================

# fifo_flags

Parameterised synchronous FIFO that sits directly upstream of the flow-control `fsm`. It buffers one data channel and produces the `full`, `empty`, `almost_full` and `almost_empty` status bits. Five instances feed the 5-bit status buses of `fsm`, with each instance driving one bit of each bus. Thresholds are programmable at run time so the `fsm` pause/continue behaviour can be exercised without resynthesis.

## Interface
Parameters:
- `DATA_WIDTH`, 6, width of stored words.
- `ADDR_WIDTH`, 3, pointer width; depth `DEPTH = 2**ADDR_WIDTH` (default 8).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `enb`  in  1  global enable; when 0 all state is frozen.
- `push`  in  1  write request.
- `data_in`  in  DATA_WIDTH  write data, sampled with `push`.
- `pop`  in  1  read request.
- `data_out`  out  DATA_WIDTH  registered read data.
- `valid_out`  out  1  `data_out` holds a newly popped word (1-cycle pulse).
- `umbral_full`  in  ADDR_WIDTH+1  almost-full threshold.
- `umbral_empty`  in  ADDR_WIDTH+1  almost-empty threshold.
- `full`  out  1  occupancy == DEPTH.
- `empty`  out  1  occupancy == 0.
- `almost_full`  out  1  occupancy >= `umbral_full`.
- `almost_empty`  out  1  occupancy <= `umbral_empty`.
- `error`  out  1  1-cycle pulse on overflow or underflow.

## Operation
- State:
  - write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits, wrapping modulo DEPTH;
  - occupancy `count`, ADDR_WIDTH+1 bits, range 0..DEPTH;
  - memory array, DEPTH x DATA_WIDTH, not reset.
- Reset (async, any time, including mid-transfer):
  - `wr_ptr`, `rd_ptr`, `count`, `data_out`, `valid_out` and `error` all go to 0;
  - flags follow from `count`=0: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=1 only if `umbral_full`==0.
- All decisions use the pre-edge `count`. With `enb`=1 at a rising edge:
  - push accepted if `count`<DEPTH, or if `count`==DEPTH and a pop is accepted in the same cycle; accepted push writes `mem[wr_ptr]` and increments `wr_ptr`;
  - pop accepted if `count`>0; accepted pop registers `mem[rd_ptr]` into `data_out`, increments `rd_ptr` and sets `valid_out`=1;
  - `count` += accepted push − accepted pop;
  - `valid_out`=0 on any edge without an accepted pop; `data_out` holds its last value.
- Overflow: push while `count`==DEPTH with no accepted pop.
  - Word is dropped; pointers and `count` are unchanged; `error`=1 for one cycle.
- Underflow: pop while `count`==0.
  - Ignored; `error`=1 for one cycle.
  - A simultaneous push is still accepted (`count` becomes 1). The FIFO has no fall-through path.
- `enb`=0: push and pop are ignored. `error`=0 and `valid_out`=0 at that edge. Pointers, `count` and `data_out` hold.
- Flags are combinational functions of registered `count` and the threshold inputs, so they are glitch-free relative to `clk`.
  - Threshold comparisons are unsigned, ADDR_WIDTH+1 bits.
  - A threshold above DEPTH is legal: `almost_full` never asserts, and `almost_empty` is always 1.

## Timing
- Push at edge N: word readable by a pop at edge N+1 or later. `empty` falls and `count` updates right after edge N.
- Pop at edge N: `data_out`/`valid_out` valid right after edge N, i.e. 1-cycle read latency.
- Full throughput: one push and one pop per cycle sustained at any occupancy from 1 to DEPTH.
- Flags change only after a clock edge, or immediately on a threshold-input change or `rst`.
- `error` is registered and asserts right after the offending edge for exactly one cycle.

## Test plan
- **Reset/idle:** assert `rst` for 2 cycles with `umbral_full`=6, `umbral_empty`=1.
  - Required: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0, `valid_out`=0, `error`=0, `data_out`=0.
- **Fill and overflow:** push 0x01..0x08 on consecutive cycles, `umbral_full`=6.
  - `almost_full` rises after the 6th push; `full` rises after the 8th.
  - A 9th push of 0x3F gives `error`=1 for one cycle and `count` stays 8.
  - Then 8 pops return 0x01..0x08 in order, each with `valid_out`=1.
- **Drain and underflow:**
  - `umbral_empty`=2: `almost_empty` rises when `count` reaches 2; `empty` rises after the last pop.
  - A further pop gives `error`=1 for one cycle, `valid_out`=0 and unchanged `data_out`.
- **Simultaneous push/pop:**
  - At `count`=8: push 0x2A with pop gives no error, `count` stays 8, 0x2A emerges after 8 more pops.
  - At `count`=0: push+pop gives `error`=1, `count`=1.
- **Wrap-around:** 20 interleaved push/pop cycles keeping `count` between 1 and 3. Output sequence equals input sequence with pointers wrapping past 7.
- **enb/async reset mid-operation:**
  - With 4 words stored, `enb`=0 for 3 cycles with push/pop active: no state change.
  - Then `rst` pulsed between edges: flags go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_flags.sv
// Synchronous FIFO with registered read data and occupancy-derived status flags
// (full/empty plus run-time programmable almost-full/almost-empty thresholds).
module fifo_flags #(
  parameter int DATA_WIDTH = 6,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enb,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out,
  input  logic [ADDR_WIDTH:0]   umbral_full,
  input  logic [ADDR_WIDTH:0]   umbral_empty,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  error
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [ADDR_WIDTH-1:0] wrPtr;
  logic [ADDR_WIDTH-1:0] rdPtr;
  logic [ADDR_WIDTH:0]   count;

  logic popOk;
  logic pushOk;
  logic overflow;
  logic underflow;

  // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
  always_comb begin
    popOk     = pop && (count != '0);
    pushOk    = push && ((count != DEPTH) || popOk);
    overflow  = push && (count == DEPTH) && !popOk;
    underflow = pop && (count == '0);
  end

  always_ff @(posedge clk) begin
    if (enb && pushOk) begin
      mem[wrPtr] <= data_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      data_out  <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else if (enb) begin
      if (pushOk) begin
        wrPtr <= wrPtr + 1'b1;
      end
      if (popOk) begin
        data_out <= mem[rdPtr];
        rdPtr    <= rdPtr + 1'b1;
      end
      valid_out <= popOk;
      error     <= overflow || underflow;
      unique case ({pushOk, popOk})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end else begin
      valid_out <= 1'b0;
      error     <= 1'b0;
    end
  end

  always_comb begin
    full         = (count == DEPTH);
    empty        = (count == '0);
    almost_full  = (count >= umbral_full);
    almost_empty = (count <= umbral_empty);
  end

endmodule

// File: tb/tb_fifo_flags.sv
// Directed bench for fifo_flags: fill/overflow, drain/underflow, simultaneous
// push/pop, pointer wrap, enable freeze and asynchronous reset between edges.
module tb_fifo_flags;

  logic       clk;
  logic       rst;
  logic       enb;
  logic       push;
  logic [5:0] data_in;
  logic       pop;
  logic [5:0] data_out;
  logic       valid_out;
  logic [3:0] umbral_full;
  logic [3:0] umbral_empty;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       error;

  int total = 0;
  int bad   = 0;

  fifo_flags #(.DATA_WIDTH(6), .ADDR_WIDTH(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .enb          (enb),
    .push         (push),
    .data_in      (data_in),
    .pop          (pop),
    .data_out     (data_out),
    .valid_out    (valid_out),
    .umbral_full  (umbral_full),
    .umbral_empty (umbral_empty),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .error        (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [5:0] q[$];
    logic [5:0] expD;
    logic       doPush;
    logic       doPop;

    rst = 1'b1; enb = 1'b0; push = 1'b0; pop = 1'b0; data_in = '0;
    umbral_full = 4'd6; umbral_empty = 4'd1;
    step();
    step();
    chk("rst_empty", empty, 1);
    chk("rst_aempty", almost_empty, 1);
    chk("rst_full", full, 0);
    chk("rst_afull", almost_full, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_error", error, 0);
    chk("rst_dout", data_out, 0);
    rst = 1'b0;
    enb = 1'b1;

    // Fill 0x01..0x08
    for (int i = 1; i <= 8; i++) begin
      push = 1'b1; data_in = 6'(i);
      step();
      chk("fill_count", dut.count, i);
      chk("fill_afull", almost_full, (i >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    data_in = 6'h3F;
    step();
    chk("ovf_error", error, 1);
    chk("ovf_count", dut.count, 8);
    chk("ovf_full", full, 1);
    push = 1'b0;
    step();
    chk("ovf_error_clr", error, 0);
    chk("ovf_count_hold", dut.count, 8);

    // Drain with almost-empty threshold 2
    umbral_empty = 4'd2;
    pop = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("drain_dout", data_out, k);
      chk("drain_valid", valid_out, 1);
      chk("drain_count", dut.count, 8 - k);
      chk("drain_aempty", almost_empty, ((8 - k) <= 2) ? 1 : 0);
      chk("drain_empty", empty, (k == 8) ? 1 : 0);
      chk("drain_error", error, 0);
    end
    step();
    chk("udf_error", error, 1);
    chk("udf_valid", valid_out, 0);
    chk("udf_dout", data_out, 8);
    chk("udf_count", dut.count, 0);
    pop = 1'b0;
    step();
    chk("udf_error_clr", error, 0);

    // Simultaneous push/pop at full
    push = 1'b1;
    for (int j = 0; j < 8; j++) begin
      data_in = 6'(8'h10 + j);
      step();
    end
    chk("sim_full", full, 1);
    data_in = 6'h2A; pop = 1'b1;
    step();
    chk("sim_full_error", error, 0);
    chk("sim_full_count", dut.count, 8);
    chk("sim_full_dout", data_out, 8'h10);
    chk("sim_full_valid", valid_out, 1);
    push = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk("sim_drain_dout", data_out, (k == 8) ? 8'h2A : 8'h10 + k);
    end
    chk("sim_drain_empty", empty, 1);

    // Simultaneous push/pop at empty: underflow flagged, push kept
    push = 1'b1; pop = 1'b1; data_in = 6'h15;
    step();
    chk("sim_empty_error", error, 1);
    chk("sim_empty_count", dut.count, 1);
    chk("sim_empty_valid", valid_out, 0);
    push = 1'b0;
    step();
    chk("sim_empty_dout", data_out, 8'h15);
    chk("sim_empty_valid2", valid_out, 1);
    chk("sim_empty_count2", dut.count, 0);
    pop = 1'b0;

    // Wrap-around with occupancy held in 1..3
    for (int i = 0; i < 20; i++) begin
      doPop  = (q.size() >= 2) && (i % 3 != 0);
      doPush = (q.size() < 3) || doPop;
      push = doPush; pop = doPop; data_in = 6'(8'h20 + i);
      expD = '0;
      if (doPop) expD = q.pop_front();
      if (doPush) q.push_back(data_in);
      step();
      chk("wrap_valid", valid_out, doPop);
      if (doPop) chk("wrap_dout", data_out, expD);
      chk("wrap_count", dut.count, q.size());
    end
    push = 1'b0; pop = 1'b0;

    // enb freeze with 4 words stored
    rst = 1'b1;
    #1;
    rst = 1'b0;
    push = 1'b1;
    for (int j = 0; j < 5; j++) begin
      data_in = 6'(8'h31 + j);
      step();
    end
    push = 1'b0; pop = 1'b1;
    step();
    chk("pre_freeze_dout", data_out, 8'h31);
    chk("pre_freeze_count", dut.count, 4);
    enb = 1'b0; push = 1'b1; pop = 1'b1; data_in = 6'h0F;
    for (int j = 0; j < 3; j++) begin
      step();
      chk("freeze_count", dut.count, 4);
      chk("freeze_dout", data_out, 8'h31);
      chk("freeze_valid", valid_out, 0);
      chk("freeze_error", error, 0);
    end
    enb = 1'b1; push = 1'b0; pop = 1'b1;
    step();
    chk("unfreeze_dout", data_out, 8'h32);
    chk("unfreeze_count", dut.count, 3);
    pop = 1'b0;

    // Threshold changes act without a clock edge
    umbral_full = 4'd3;
    #1;
    chk("thr_afull_low", almost_full, 1);
    umbral_full = 4'd15; umbral_empty = 4'd15;
    #1;
    chk("thr_afull_high", almost_full, 0);
    chk("thr_aempty_high", almost_empty, 1);
    umbral_full = 4'd0; umbral_empty = 4'd1;
    #1;
    chk("thr_aempty_low", almost_empty, 0);

    // Asynchronous reset between edges
    rst = 1'b1;
    #1;
    chk("arst_empty", empty, 1);
    chk("arst_aempty", almost_empty, 1);
    chk("arst_full", full, 0);
    chk("arst_afull_thr0", almost_full, 1);
    chk("arst_count", dut.count, 0);
    chk("arst_dout", data_out, 0);
    step();
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
